coin_intake: RTL and testbench
==============================

Name: coin_intake

Overview:
- Payment front-end that sits directly upstream of the game credit counter.
- Collects coin events into a pending credit within one transaction, then commits it as a single-cycle `set` pulse with a 10-bit `money` value.
- The credit counter adds the committed `money` to its remaining credit.
- Also handles cancel/refund, inactivity timeout, invalid coins and over-cap rejection.

Parameters:
- MAX_CREDIT, 500: maximum pending credit per transaction. Range 1..1023.
- TIMEOUT, 16: idle cycles in COLLECT before an automatic commit. Must be ≥ 2.
- VAL0, 1: credit value of coin_type 2'b00.
- VAL1, 5: credit value of coin_type 2'b01.
- VAL2, 10: credit value of coin_type 2'b10.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- coin_valid  in  1  one coin event this cycle
- coin_type  in  2  denomination; 2'b11 is invalid
- confirm  in  1  player requests commit
- cancel  in  1  player requests refund of pending credit
- money  out  10  committed amount; valid only while set=1
- set  out  1  one-cycle commit strobe to the credit counter
- refund_valid  out  1  one-cycle refund strobe
- refund_amt  out  10  refunded amount; valid only while refund_valid=1
- reject  out  1  one-cycle pulse: the coin sampled on the previous edge was rejected
- pending  out  10  current pending credit
- busy  out  1  high while state is COLLECT

Behaviour:
- Interface: single clock `clk`; reset `rst_n` is asynchronous, active low.
- Reset values: all outputs 0; state IDLE; pending 0; timeout counter 0. An asserted reset discards any pending credit with no refund pulse.
- Output registration: all outputs are registered. Strobes (set, refund_valid, reject) rise in the cycle after the sampling edge and last exactly one cycle. money and refund_amt are 0 whenever their strobe is low.
- Coin accept rule: val = VALn per coin_type. The coin is accepted iff coin_type != 2'b11 and pending + val ≤ MAX_CREDIT. Compute the sum at 11 bits; no wrap is allowed.
- Rejected coins: pending is unchanged, reject pulses, and the state does not change because of that coin.
- FSM states: IDLE, COLLECT.
- IDLE:
  - An accepted coin loads pending = val and moves to COLLECT; the timer clears.
  - confirm and cancel are ignored; no strobes are produced.
- COLLECT, evaluated in priority order on each edge:
  1. cancel=1: refund_amt ← pending (+ val if a coin is accepted in the same cycle), refund_valid=1, pending←0, go to IDLE. cancel beats confirm when both are high.
  2. confirm=1: money ← pending (+ val if a coin is accepted in the same cycle), set=1, pending←0, go to IDLE.
  3. Accepted coin only: pending += val; the timer clears.
  4. No event: timer += 1. When the timer reaches TIMEOUT-1 (TIMEOUT idle cycles elapsed), auto-commit exactly as confirm does.
- Timer and rejections: a rejected coin does not clear the timer. It counts as an idle cycle.
- Back-to-back transactions: a coin arriving in the cycle right after a commit or refund (while set/refund_valid is high) is accepted normally from IDLE.
- Throughput: one coin per cycle is sustained. Any number of commits may occur without gaps.
- Value guarantees:
  - Commit values satisfy 1 ≤ money ≤ MAX_CREDIT.
  - money is never 0 when set=1, so the credit counter never receives an empty set.
- Downstream ownership: no backpressure. The downstream counter must accept set in any cycle; saturating its remaining credit is its own responsibility.

Decomposition:
- Shared package (game_pkg):
  - state enum {IDLE, COLLECT};
  - coin-type encoding constants COIN_A/B/C/INV;
  - money width constant MONEY_W=10.
- Sub-module coin_value_lut:
  - combinational coin_type → {val, valid} using VAL0..VAL2.
  - Instantiated once; the rest of the logic stays in coin_intake.

Test Plan:
- Reset, coins 00,01,10 on consecutive cycles, then confirm → pending 1,6,16; set=1 for one cycle with money=16; pending=0; busy=0.
- Coin 10 then cancel asserted with coin 01 in the same cycle → refund_valid=1, refund_amt=15, set never asserted.
- MAX_CREDIT=20: coins 10,10,then 01 → third coin reject=1, pending stays 20; confirm → money=20.
- coin_type 2'b11 in IDLE → reject=1, state stays IDLE, busy=0; confirm then → no set.
- TIMEOUT=16: single coin 01, then no inputs → set=1 with money=5 exactly 16 cycles after the coin edge. A rejected coin mid-wait does not delay the commit.
- Coin 01 then confirm and cancel together → refund 5, no set. Coin 10, wait 3 cycles, then drop rst_n → pending=0, busy=0, no strobes; a coin after release starts a fresh transaction.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the payment front-end: FSM state encoding,
// coin-type codes and the width of committed money values.
package game_pkg;
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [1:0] COIN_A   = 2'b00;
    localparam logic [1:0] COIN_B   = 2'b01;
    localparam logic [1:0] COIN_C   = 2'b10;
    localparam logic [1:0] COIN_INV = 2'b11;

    localparam int MONEY_W = 10;
endpackage

// File: rtl/coin_value_lut.sv
// Maps a coin denomination code to its credit value; the invalid code
// yields valid=0 and a zero value.
module coin_value_lut
    import game_pkg::*;
#(
    parameter int VAL0 = 1,
    parameter int VAL1 = 5,
    parameter int VAL2 = 10
) (
    input  logic [1:0]         coin_type,
    output logic [MONEY_W-1:0] val,
    output logic               valid
);
    always_comb begin
        val   = '0;
        valid = 1'b0;
        case (coin_type)
            COIN_A: begin
                val   = MONEY_W'(VAL0);
                valid = 1'b1;
            end
            COIN_B: begin
                val   = MONEY_W'(VAL1);
                valid = 1'b1;
            end
            COIN_C: begin
                val   = MONEY_W'(VAL2);
                valid = 1'b1;
            end
            default: begin
                val   = '0;
                valid = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/coin_intake.sv
// Coin collection front-end: accumulates accepted coins into a pending credit
// and hands it to the credit counter as a one-cycle set/money commit.
module coin_intake
    import game_pkg::*;
#(
    parameter int MAX_CREDIT = 500,
    parameter int TIMEOUT    = 16,
    parameter int VAL0       = 1,
    parameter int VAL1       = 5,
    parameter int VAL2       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coin_valid,
    input  logic [1:0]         coin_type,
    input  logic               confirm,
    input  logic               cancel,
    output logic [MONEY_W-1:0] money,
    output logic               set,
    output logic               refund_valid,
    output logic [MONEY_W-1:0] refund_amt,
    output logic               reject,
    output logic [MONEY_W-1:0] pending,
    output logic               busy
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [MONEY_W:0]   CAP        = (MONEY_W + 1)'(MAX_CREDIT);

    // Strobes are push-only: the counter downstream has no ready and must
    // take set/money in whatever cycle it appears.
    state_t             state_q, state_n;
    logic [MONEY_W-1:0] pending_q, pending_n;
    logic [TW-1:0]      timer_q, timer_n;
    logic [MONEY_W-1:0] money_n, refund_amt_n;
    logic               set_n, refund_valid_n, reject_n;

    logic [MONEY_W-1:0] val;
    logic               val_ok;
    logic [MONEY_W:0]   sum;
    logic               accept;
    logic [MONEY_W-1:0] total;

    coin_value_lut #(
        .VAL0(VAL0),
        .VAL1(VAL1),
        .VAL2(VAL2)
    ) u_lut (
        .coin_type(coin_type),
        .val      (val),
        .valid    (val_ok)
    );

    // 11-bit sum so an over-cap coin can never wrap into an acceptable value.
    assign sum    = {1'b0, pending_q} + {1'b0, val};
    assign accept = coin_valid && val_ok && (sum <= CAP);
    assign total  = accept ? sum[MONEY_W-1:0] : pending_q;

    always_comb begin
        state_n        = state_q;
        pending_n      = pending_q;
        timer_n        = timer_q;
        set_n          = 1'b0;
        money_n        = '0;
        refund_valid_n = 1'b0;
        refund_amt_n   = '0;
        reject_n       = coin_valid && !accept;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pending_n = val;
                    timer_n   = '0;
                    state_n   = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    refund_valid_n = 1'b1;
                    refund_amt_n   = total;
                    pending_n      = '0;
                    timer_n        = '0;
                    state_n        = IDLE;
                end else if (confirm) begin
                    set_n     = 1'b1;
                    money_n   = total;
                    pending_n = '0;
                    timer_n   = '0;
                    state_n   = IDLE;
                end else if (accept) begin
                    pending_n = sum[MONEY_W-1:0];
                    timer_n   = '0;
                end else if (timer_q == TIMER_LAST) begin
                    set_n     = 1'b1;
                    money_n   = pending_q;
                    pending_n = '0;
                    timer_n   = '0;
                    state_n   = IDLE;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                pending_n = '0;
                timer_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            timer_q      <= '0;
            set          <= 1'b0;
            money        <= '0;
            refund_valid <= 1'b0;
            refund_amt   <= '0;
            reject       <= 1'b0;
        end else begin
            state_q      <= state_n;
            pending_q    <= pending_n;
            timer_q      <= timer_n;
            set          <= set_n;
            money        <= money_n;
            refund_valid <= refund_valid_n;
            refund_amt   <= refund_amt_n;
            reject       <= reject_n;
        end
    end

    assign pending = pending_q;
    assign busy    = (state_q == COLLECT);
endmodule

// File: tb/tb_coin_intake.sv
// Directed bench for coin_intake: a per-cycle vector table plus hand-written
// timeout and asynchronous-reset sequences.
module tb_coin_intake;
    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       confirm;
    logic       cancel;
    logic [9:0] money;
    logic       set;
    logic       refund_valid;
    logic [9:0] refund_amt;
    logic       reject;
    logic [9:0] pending;
    logic       busy;

    int n_cmp;
    int n_bad;

    coin_intake #(
        .MAX_CREDIT(20),
        .TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .confirm     (confirm),
        .cancel      (cancel),
        .money       (money),
        .set         (set),
        .refund_valid(refund_valid),
        .refund_amt  (refund_amt),
        .reject      (reject),
        .pending     (pending),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [1:0] ct;
        logic       cf;
        logic       cn;
        logic       e_set;
        int         e_money;
        logic       e_rv;
        int         e_ramt;
        logic       e_rej;
        int         e_pend;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_step(input logic cv, input logic [1:0] ct, input logic cf, input logic cn);
        @(negedge clk);
        coin_valid = cv;
        coin_type  = ct;
        confirm    = cf;
        cancel     = cn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_set, input int e_money,
                           input logic e_rv, input int e_ramt, input logic e_rej,
                           input int e_pend, input logic e_busy);
        chk({tag, ".set"}, int'(set), int'(e_set));
        chk({tag, ".money"}, int'(money), e_money);
        chk({tag, ".refund_valid"}, int'(refund_valid), int'(e_rv));
        chk({tag, ".refund_amt"}, int'(refund_amt), e_ramt);
        chk({tag, ".reject"}, int'(reject), int'(e_rej));
        chk({tag, ".pending"}, int'(pending), e_pend);
        chk({tag, ".busy"}, int'(busy), int'(e_busy));
    endtask

    task automatic add(input logic cv, input logic [1:0] ct, input logic cf, input logic cn,
                       input logic s, input int m, input logic rv, input int ra,
                       input logic rj, input int p, input logic b);
        vec_t v;
        v.cv = cv; v.ct = ct; v.cf = cf; v.cn = cn;
        v.e_set = s; v.e_money = m; v.e_rv = rv; v.e_ramt = ra;
        v.e_rej = rj; v.e_pend = p; v.e_busy = b;
        vecs.push_back(v);
    endtask

    // Idle-wait after a coin: set must appear only on the TIMEOUT-th idle edge.
    task automatic timeout_run(input string tag, input int rej_at, input int e_money, input int e_pend);
        for (int k = 1; k <= 16; k++) begin
            if (k == rej_at) drive_step(1'b1, 2'b11, 1'b0, 1'b0);
            else             drive_step(1'b0, 2'b00, 1'b0, 1'b0);
            chk($sformatf("%s.set[%0d]", tag, k), int'(set), (k == 16) ? 1 : 0);
            chk($sformatf("%s.money[%0d]", tag, k), int'(money), (k == 16) ? e_money : 0);
            chk($sformatf("%s.busy[%0d]", tag, k), int'(busy), (k == 16) ? 0 : 1);
            chk($sformatf("%s.pending[%0d]", tag, k), int'(pending), (k == 16) ? 0 : e_pend);
            chk($sformatf("%s.reject[%0d]", tag, k), int'(reject), (k == rej_at) ? 1 : 0);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        coin_valid = 1'b0;
        coin_type  = 2'b00;
        confirm    = 1'b0;
        cancel     = 1'b0;

        //   cv  ct     cf  cn  set money rv  ramt rej pend busy
        add(1, 2'b00, 0, 0, 0, 0,  0, 0,  0, 1,  1);
        add(1, 2'b01, 0, 0, 0, 0,  0, 0,  0, 6,  1);
        add(1, 2'b10, 0, 0, 0, 0,  0, 0,  0, 16, 1);
        add(0, 2'b00, 1, 0, 1, 16, 0, 0,  0, 0,  0);
        add(0, 2'b00, 0, 0, 0, 0,  0, 0,  0, 0,  0);
        add(1, 2'b10, 0, 0, 0, 0,  0, 0,  0, 10, 1);
        add(1, 2'b01, 0, 1, 0, 0,  1, 15, 0, 0,  0);
        add(1, 2'b10, 0, 0, 0, 0,  0, 0,  0, 10, 1);
        add(1, 2'b10, 0, 0, 0, 0,  0, 0,  0, 20, 1);
        add(1, 2'b01, 0, 0, 0, 0,  0, 0,  1, 20, 1);
        add(0, 2'b00, 1, 0, 1, 20, 0, 0,  0, 0,  0);
        add(1, 2'b11, 0, 0, 0, 0,  0, 0,  1, 0,  0);
        add(0, 2'b00, 1, 0, 0, 0,  0, 0,  0, 0,  0);
        add(0, 2'b00, 0, 1, 0, 0,  0, 0,  0, 0,  0);
        add(1, 2'b01, 0, 0, 0, 0,  0, 0,  0, 5,  1);
        add(0, 2'b00, 1, 1, 0, 0,  1, 5,  0, 0,  0);
        add(1, 2'b01, 0, 0, 0, 0,  0, 0,  0, 5,  1);
        add(1, 2'b10, 1, 0, 1, 15, 0, 0,  0, 0,  0);
        add(1, 2'b00, 0, 0, 0, 0,  0, 0,  0, 1,  1);
        add(1, 2'b11, 1, 0, 1, 1,  0, 0,  1, 0,  0);
        add(1, 2'b10, 0, 0, 0, 0,  0, 0,  0, 10, 1);
        add(1, 2'b10, 1, 0, 1, 20, 0, 0,  0, 0,  0);
        add(0, 2'b00, 0, 0, 0, 0,  0, 0,  0, 0,  0);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive_step(vecs[i].cv, vecs[i].ct, vecs[i].cf, vecs[i].cn);
            chk_all($sformatf("vec%0d", i), vecs[i].e_set, vecs[i].e_money, vecs[i].e_rv,
                    vecs[i].e_ramt, vecs[i].e_rej, vecs[i].e_pend, vecs[i].e_busy);
        end

        // Timeout with a rejected coin mid-wait: still commits on idle edge 16.
        drive_step(1'b1, 2'b01, 1'b0, 1'b0);
        chk_all("to1.load", 0, 0, 0, 0, 0, 5, 1);
        timeout_run("to1", 5, 5, 5);

        // An accepted coin restarts the idle count.
        drive_step(1'b1, 2'b01, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) drive_step(1'b0, 2'b00, 1'b0, 1'b0);
        chk_all("to2.wait", 0, 0, 0, 0, 0, 5, 1);
        drive_step(1'b1, 2'b00, 1'b0, 1'b0);
        chk_all("to2.restart", 0, 0, 0, 0, 0, 6, 1);
        timeout_run("to2", 0, 6, 6);
        drive_step(1'b0, 2'b00, 1'b0, 1'b0);
        chk_all("to2.after", 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-transaction discards credit without a refund.
        drive_step(1'b1, 2'b10, 1'b0, 1'b0);
        repeat (3) drive_step(1'b0, 2'b00, 1'b0, 1'b0);
        chk_all("rst.pre", 0, 0, 0, 0, 0, 10, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst.async", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst.hold", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_step(1'b1, 2'b01, 1'b0, 1'b0);
        chk_all("rst.fresh", 0, 0, 0, 0, 0, 5, 1);
        drive_step(1'b0, 2'b00, 1'b1, 1'b0);
        chk_all("rst.commit", 1, 5, 0, 0, 0, 0, 0);
        drive_step(1'b0, 2'b00, 1'b0, 1'b0);
        chk_all("rst.quiet", 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
